mem_access_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, sitting between the EX/MEM register and the MEM/WB register. It turns load and store requests into word-aligned data-bus transactions with a req/ack handshake, stalls upstream until each transaction completes, and lane-steers and extends load data. It presents the writeback fields in the exact form the MEM/WB register captures.

---
 rtl/mem_access_pkg.sv | 41 ++++
 rtl/mem_access_stage_align.sv | 53 +++++
 rtl/mem_access_stage.sv | 135 +++++++++++++
 tb/tb_mem_access_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types for the memory-access stage.
// State encoding, access sizes and RV32I funct3 constants.
package mem_access_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned sizes only exist for loads; anything
  // unrecognised collapses to a full word.
  function automatic size_e access_size(
    input logic [2:0] f3,
    input logic       is_load
  );
    size_e sz;
    sz = SZ_W;
    unique case (1'b1)
      (f3 == F3_B):             sz = SZ_B;
      (f3 == F3_H):             sz = SZ_H;
      (is_load && f3 == F3_BU): sz = SZ_B;
      (is_load && f3 == F3_HU): sz = SZ_H;
      default:                  sz = SZ_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_access_stage_align.sv
// Byte-lane steering for stores and lane
// extraction plus sign/zero extension for loads.
module load_store_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        is_load,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_result
);

  size_e       sz;
  logic        zext;
  logic [7:0]  lb;
  logic [15:0] lh;

  assign sz   = access_size(funct3, is_load);
  assign zext = funct3[2];
  assign lb   = load_word[{addr_lo, 3'b000} +: 8];
  assign lh   = addr_lo[1] ? load_word[31:16]
                           : load_word[15:0];

  // Size decode drives both store and load lanes.
  always_comb begin
    wstrb       = 4'hF;
    wdata       = store_data;
    load_result = load_word;
    unique case (sz)
      SZ_B: begin
        wstrb       = 4'b0001 << addr_lo;
        wdata       = {4{store_data[7:0]}};
        load_result = zext ? {24'h0, lb}
                           : {{24{lb[7]}}, lb};
      end
      SZ_H: begin
        wstrb       = 4'b0011 << {addr_lo[1], 1'b0};
        wdata       = {2{store_data[15:0]}};
        load_result = zext ? {16'h0, lh}
                           : {{16{lh[15]}}, lh};
      end
      default: begin
        wstrb       = 4'hF;
        wdata       = store_data;
        load_result = load_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: req/ack bus master with upstream stall.
// Optional MEM_ACCESS_MISALIGN_TRAP_EN blocks misaligned accesses.
module mem_access_stage
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_address,
  input  logic [31:0] in_store_data,
  input  logic [31:0] in_alu_rd_result,
  input  logic [31:0] in_next_pc,
  input  logic [4:0]  in_rd_address,
  input  logic        in_reg_write_data_src,
  input  logic        in_reg_wren,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] ram_data,
  output logic [31:0] alu_rd_result,
  output logic [4:0]  rd_address,
  output logic        reg_write_data_src,
  output logic [31:0] next_pc,
  output logic        reg_wren,
  output logic        misaligned_fault
);

  state_e      state;
  logic [31:0] load_reg;
  logic        access;
  logic        is_load;
  logic        misaligned;
  logic        issue;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  assign access  = in_valid & (in_mem_read | in_mem_write);
  assign is_load = in_mem_read;

  load_store_align u_align (
    .funct3      (in_funct3),
    .is_load     (is_load),
    .addr_lo     (in_address[1:0]),
    .store_data  (in_store_data),
    .load_word   (load_reg),
    .wstrb       (al_wstrb),
    .wdata       (al_wdata),
    .load_result (al_rdata)
  );

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  size_e sz;
  assign sz = access_size(in_funct3, is_load);
  assign misaligned = access &
    (((sz == SZ_H) & in_address[0]) |
     ((sz == SZ_W) & (|in_address[1:0])));
`else
  assign misaligned = 1'b0;
`endif

  assign misaligned_fault   = (state == S_IDLE) & misaligned;
  assign issue              = (state == S_IDLE) & access & ~misaligned;
  assign alu_rd_result      = in_alu_rd_result;
  assign rd_address         = in_rd_address;
  assign reg_write_data_src = in_reg_write_data_src;
  assign next_pc            = in_next_pc;

  // Bus master FSM; bus fields latched once at issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'h0;
      load_reg  <= 32'h0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (issue) begin
            state     <= S_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= ~is_load;
            mem_addr  <= {in_address[31:2], 2'b00};
            mem_wdata <= is_load ? 32'h0 : al_wdata;
            mem_wstrb <= is_load ? 4'h0 : al_wstrb;
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            state    <= S_DONE;
            mem_req  <= 1'b0;
            load_reg <= mem_rdata;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stall, writeback enable and load result per state.
  always_comb begin
    stall    = 1'b0;
    reg_wren = 1'b0;
    ram_data = 32'h0;
    unique case (state)
      S_IDLE: begin
        stall    = issue;
        reg_wren = in_valid & in_reg_wren & ~access;
      end
      S_BUSY: stall = 1'b1;
      S_DONE: begin
        reg_wren = in_reg_wren;
        ram_data = is_load ? al_rdata : 32'h0;
      end
      default: begin
        stall    = 1'b0;
        reg_wren = 1'b0;
        ram_data = 32'h0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage.
// Driver queues expectations; negedge monitor checks them.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_mem_read, in_mem_write;
  logic [2:0]  in_funct3;
  logic [31:0] in_address, in_store_data;
  logic [31:0] in_alu_rd_result, in_next_pc;
  logic [4:0]  in_rd_address;
  logic        in_reg_write_data_src, in_reg_wren;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [31:0] ram_data, alu_rd_result, next_pc;
  logic [4:0]  rd_address;
  logic        reg_write_data_src, reg_wren;
  logic        misaligned_fault;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_t;

  typedef struct {
    logic [31:0] ram;
    logic        wren;
    logic [31:0] alu;
    int          stalls;
    int          reqs;
    logic        fault;
  } wb_t;

  bus_t bus_q[$];
  wb_t  wb_q[$];

  mem_access_stage dut (
    .clk                   (clk),
    .reset                 (reset),
    .in_valid              (in_valid),
    .in_mem_read           (in_mem_read),
    .in_mem_write          (in_mem_write),
    .in_funct3             (in_funct3),
    .in_address            (in_address),
    .in_store_data         (in_store_data),
    .in_alu_rd_result      (in_alu_rd_result),
    .in_next_pc            (in_next_pc),
    .in_rd_address         (in_rd_address),
    .in_reg_write_data_src (in_reg_write_data_src),
    .in_reg_wren           (in_reg_wren),
    .mem_req               (mem_req),
    .mem_we                (mem_we),
    .mem_addr              (mem_addr),
    .mem_wdata             (mem_wdata),
    .mem_wstrb             (mem_wstrb),
    .mem_ack               (mem_ack),
    .mem_rdata             (mem_rdata),
    .stall                 (stall),
    .ram_data              (ram_data),
    .alu_rd_result         (alu_rd_result),
    .rd_address            (rd_address),
    .reg_write_data_src    (reg_write_data_src),
    .next_pc               (next_pc),
    .reg_wren              (reg_wren),
    .misaligned_fault      (misaligned_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Monitor: bus fields on req rise, writeback on retire.
  always @(negedge clk) begin : mon
    bus_t b;
    wb_t  w;
    static int  stall_cnt = 0;
    static int  req_cnt   = 0;
    static logic prev_req = 1'b0;
    if (reset) begin
      stall_cnt = 0;
      req_cnt   = 0;
      prev_req  = 1'b0;
    end else begin
      if (mem_req && !prev_req) begin
        if (bus_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL bus_unexpected: got req at %h expected none",
                   mem_addr);
        end else begin
          b = bus_q.pop_front();
          check("mem_addr", mem_addr, b.addr);
          check("mem_we", {31'h0, mem_we}, {31'h0, b.we});
          check("mem_wdata", mem_wdata, b.wdata);
          check("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, b.wstrb});
        end
      end
      if (mem_req) req_cnt++;
      if (stall) begin
        stall_cnt++;
        check("wren_in_stall", {31'h0, reg_wren}, 32'h0);
      end else if (in_valid) begin
        if (wb_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL wb_unexpected: got retire expected none");
        end else begin
          w = wb_q.pop_front();
          check("ram_data", ram_data, w.ram);
          check("reg_wren", {31'h0, reg_wren}, {31'h0, w.wren});
          check("alu_pass", alu_rd_result, w.alu);
          check("stall_cycles", stall_cnt, w.stalls);
          check("req_cycles", req_cnt, w.reqs);
          check("fault", {31'h0, misaligned_fault},
                {31'h0, w.fault});
        end
        stall_cnt = 0;
        req_cnt   = 0;
      end
      prev_req = mem_req;
    end
  end

  task automatic clear_inputs();
    in_valid = 0; in_mem_read = 0; in_mem_write = 0;
    in_funct3 = 3'b010; in_address = 0; in_store_data = 0;
    in_alu_rd_result = 0; in_next_pc = 0; in_rd_address = 0;
    in_reg_write_data_src = 0; in_reg_wren = 0;
  endtask

  // Present one instruction, ack after wn BUSY cycles.
  task automatic issue(
    input logic rd, input logic wr,
    input logic [2:0] f3, input logic [31:0] a,
    input logic [31:0] sd, input logic [31:0] rdv,
    input int wn, input logic wren,
    input logic [31:0] e_addr, input logic [31:0] e_wdata,
    input logic [3:0] e_strb, input logic [31:0] e_ram,
    input int e_stall, input logic e_fault);
    bus_t b;
    wb_t  w;
    int   wc = 0;
    int   n = 0;
    bit   done = 0;
    in_valid = 1; in_mem_read = rd; in_mem_write = wr;
    in_funct3 = f3; in_address = a; in_store_data = sd;
    in_alu_rd_result = a ^ 32'h5A5A_0000;
    in_next_pc = a + 4; in_rd_address = 5'd7;
    in_reg_write_data_src = rd; in_reg_wren = wren;
    mem_rdata = rdv;
    if ((rd || wr) && !e_fault) begin
      b.addr = e_addr; b.we = wr & ~rd;
      b.wdata = e_wdata; b.wstrb = e_strb;
      bus_q.push_back(b);
    end
    w.ram = e_ram; w.wren = wren & ~e_fault;
    w.alu = a ^ 32'h5A5A_0000; w.stalls = e_stall;
    w.reqs = ((rd || wr) && !e_fault) ? wn + 1 : 0;
    w.fault = e_fault;
    wb_q.push_back(w);
    while (!done && n < 50) begin
      @(negedge clk);
      if (!stall) done = 1;
      else if (mem_req) begin
        if (wc == wn) mem_ack = 1;
        wc++;
      end
      @(posedge clk);
      #1;
      mem_ack = 0;
      n++;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL timeout: got stall stuck expected retire at %h", a);
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1;
    mem_ack = 0;
    mem_rdata = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'h0, mem_req}, 32'h0);
    check("rst_we", {31'h0, mem_we}, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_wstrb", {28'h0, mem_wstrb}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_fault", {31'h0, misaligned_fault}, 32'h0);
    reset = 0;
    @(posedge clk);
    #1;

    // rd wr f3 addr sdata rdata wait wren | addr wdata strb ram stall fault
    issue(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0,
          32'h100, 32'hDEADBEEF, 4'hF, 0, 2, 0);
    issue(1, 0, 3'b000, 32'h103, 0, 32'h80FFFF7F, 0, 1,
          32'h100, 0, 4'h0, 32'hFFFFFF80, 2, 0);
    issue(1, 0, 3'b100, 32'h103, 0, 32'h80FFFF7F, 0, 1,
          32'h100, 0, 4'h0, 32'h00000080, 2, 0);
    issue(0, 1, 3'b001, 32'h22, 32'h1234, 0, 3, 0,
          32'h20, 32'h12341234, 4'b1100, 0, 5, 0);
    issue(0, 0, 3'b000, 32'hCAFEF00D, 0, 0, 0, 1,
          0, 0, 4'h0, 0, 0, 0);
    issue(1, 0, 3'b001, 32'h06, 0, 32'h80017FFF, 0, 1,
          32'h04, 0, 4'h0, 32'hFFFF8001, 2, 0);
    issue(1, 0, 3'b101, 32'h06, 0, 32'h80017FFF, 0, 1,
          32'h04, 0, 4'h0, 32'h00008001, 2, 0);
    issue(0, 1, 3'b000, 32'h0D, 32'h123456A5, 0, 0, 0,
          32'h0C, 32'hA5A5A5A5, 4'b0010, 0, 2, 0);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    issue(1, 0, 3'b010, 32'h102, 0, 32'h11223344, 0, 1,
          32'h100, 0, 4'h0, 0, 0, 1);
`else
    issue(1, 0, 3'b010, 32'h102, 0, 32'h11223344, 0, 1,
          32'h100, 0, 4'h0, 32'h11223344, 2, 0);
`endif
    issue(1, 0, 3'b000, 32'h100, 0, 32'h80FFFF7F, 1, 1,
          32'h100, 0, 4'h0, 32'h0000007F, 3, 0);
    issue(1, 1, 3'b010, 32'h40, 32'h99, 32'h55AA55AA, 0, 1,
          32'h40, 0, 4'h0, 32'h55AA55AA, 2, 0);
    issue(0, 1, 3'b100, 32'h40, 32'h01020304, 0, 0, 0,
          32'h40, 32'h01020304, 4'hF, 0, 2, 0);

    // Reset during BUSY; late ack must be dropped.
    begin
      bus_t b;
      b.addr = 32'h200; b.we = 0; b.wdata = 0; b.wstrb = 0;
      bus_q.push_back(b);
      in_valid = 1; in_mem_read = 1; in_funct3 = 3'b010;
      in_address = 32'h200; in_reg_wren = 1;
      mem_rdata = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("busy_req", {31'h0, mem_req}, 32'h1);
      @(posedge clk);
      #1;
      reset = 1;
      clear_inputs();
      @(posedge clk);
      #1;
      reset = 0;
      check("rstbusy_req", {31'h0, mem_req}, 32'h0);
      check("rstbusy_stall", {31'h0, stall}, 32'h0);
      mem_ack = 1;
      @(posedge clk);
      #1;
      mem_ack = 0;
      check("lateack_req", {31'h0, mem_req}, 32'h0);
      check("lateack_stall", {31'h0, stall}, 32'h0);
      check("lateack_ram", ram_data, 32'h0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("bus_q_empty", bus_q.size(), 32'h0);
    check("wb_q_empty", wb_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
